// File: rtl/crc_pkg.sv
// crc_pkg: shared types, presets and pure functions for the streaming CRC engine.
//   crc_state_t  - engine FSM states
//   crc_preset_t - bundle of per-frame CRC parameters (normal-form polynomial)
//   crc_step     - direct (non-augmented) CRC update over one data beat, MSB first
//   bit_reverse  - reverse the low w bits of a vector
package crc_pkg;

  localparam int unsigned CRC_MAX_W  = 32;
  localparam int unsigned DATA_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } crc_state_t;

  typedef struct packed {
    logic [CRC_MAX_W-1:0] poly;
    logic [CRC_MAX_W-1:0] init;
    logic [CRC_MAX_W-1:0] xorout;
    logic                 refin;
    logic                 refout;
  } crc_preset_t;

  localparam crc_preset_t CRC8_SMBUS = '{
    poly: 32'h07, init: 32'h00, xorout: 32'h00, refin: 1'b0, refout: 1'b0};
  localparam crc_preset_t CRC8_DVB_S2 = '{
    poly: 32'hD5, init: 32'h00, xorout: 32'h00, refin: 1'b0, refout: 1'b0};
  localparam crc_preset_t CRC8_GSM_A = '{
    poly: 32'h1D, init: 32'h00, xorout: 32'h00, refin: 1'b0, refout: 1'b0};
  localparam crc_preset_t CRC16_CCITT_FALSE = '{
    poly: 32'h1021, init: 32'hFFFF, xorout: 32'h0000, refin: 1'b0, refout: 1'b0};
  localparam crc_preset_t CRC32_ETH = '{
    poly: 32'h04C11DB7, init: 32'hFFFFFFFF, xorout: 32'hFFFFFFFF, refin: 1'b1, refout: 1'b1};

  // One beat of the direct algorithm: cw-bit register, dw data bits, MSB first.
  function automatic logic [CRC_MAX_W-1:0] crc_step(
    input logic [CRC_MAX_W-1:0]  crc,
    input logic [DATA_MAX_W-1:0] data,
    input logic [CRC_MAX_W-1:0]  poly,
    input int unsigned           cw,
    input int unsigned           dw
  );
    logic [CRC_MAX_W-1:0] mask;
    logic [CRC_MAX_W-1:0] c;
    logic                 fb;
    mask = (cw >= CRC_MAX_W) ? '1 : ((CRC_MAX_W'(1) << cw) - CRC_MAX_W'(1));
    c    = crc & mask;
    for (int i = int'(DATA_MAX_W) - 1; i >= 0; i--) begin
      if (i < int'(dw)) begin
        fb = c[5'(cw - 32'd1)] ^ data[6'(i)];
        c  = ((c << 1) ^ (fb ? poly : '0)) & mask;
      end
    end
    return c;
  endfunction

  // Reverse bit order of v[w-1:0]; bits above w come back as zero.
  function automatic logic [DATA_MAX_W-1:0] bit_reverse(
    input logic [DATA_MAX_W-1:0] v,
    input int unsigned           w
  );
    logic [DATA_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DATA_MAX_W); i++) begin
      if (i < int'(w)) begin
        r[6'(i)] = v[6'(int'(w) - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_step_comb.sv
// crc_step_comb: fully unrolled single-cycle CRC update for one beat.
//   crc_i  - current register value
//   data_i - beat data, already reflected if required, MSB processed first
//   poly_i - normal-form polynomial (implicit leading 1 omitted)
//   crc_o  - register value after all DATA_WIDTH bits
module crc_step_comb
  import crc_pkg::*;
#(
  parameter int unsigned CRC_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [CRC_WIDTH-1:0]  crc_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CRC_WIDTH-1:0]  poly_i,
  output logic [CRC_WIDTH-1:0]  crc_o
);

  always_comb begin
    crc_o = CRC_WIDTH'(crc_step(CRC_MAX_W'(crc_i), DATA_MAX_W'(data_i),
                                CRC_MAX_W'(poly_i), CRC_WIDTH, DATA_WIDTH));
  end

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming CRC over valid/ready beats, one frame in flight.
//   clk, rst_n         - clock, synchronous active-low reset
//   cfg_*              - per-frame CRC parameters, latched on the first beat
//   s_valid/s_ready    - input beat handshake; s_data beat, s_last end of frame
//   abort              - drop the frame in progress (honoured only while running)
//   m_valid/m_ready    - result handshake; m_crc final CRC, m_match == cfg_check
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int unsigned CRC_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CRC_WIDTH-1:0]  cfg_poly,
  input  logic [CRC_WIDTH-1:0]  cfg_init,
  input  logic [CRC_WIDTH-1:0]  cfg_xorout,
  input  logic                  cfg_refin,
  input  logic                  cfg_refout,
  input  logic [CRC_WIDTH-1:0]  cfg_check,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  abort,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CRC_WIDTH-1:0]  m_crc,
  output logic                  m_match
);

  crc_state_t            state_q;
  logic [CRC_WIDTH-1:0]  crc_q;
  logic [CRC_WIDTH-1:0]  poly_q;
  logic [CRC_WIDTH-1:0]  xorout_q;
  logic [CRC_WIDTH-1:0]  check_q;
  logic                  refin_q;
  logic                  refout_q;
  logic                  s_ready_q;
  logic                  m_valid_q;
  logic [CRC_WIDTH-1:0]  m_crc_q;
  logic                  m_match_q;

  logic                  beat_acc_c;
  logic                  in_idle_c;
  logic                  refin_c;
  logic [CRC_WIDTH-1:0]  step_crc_c;
  logic [CRC_WIDTH-1:0]  step_poly_c;
  logic [DATA_WIDTH-1:0] step_data_c;
  logic [CRC_WIDTH-1:0]  crc_d;
  logic [CRC_WIDTH-1:0]  result_c;

  assign beat_acc_c = s_valid & s_ready_q;
  assign in_idle_c  = (state_q == IDLE);

  // First beat of a frame uses the live cfg inputs; later beats the latched copy.
  always_comb begin
    refin_c     = in_idle_c ? cfg_refin : refin_q;
    step_crc_c  = in_idle_c ? cfg_init  : crc_q;
    step_poly_c = in_idle_c ? cfg_poly  : poly_q;
    step_data_c = refin_c ? DATA_WIDTH'(bit_reverse(DATA_MAX_W'(s_data), DATA_WIDTH))
                          : s_data;
  end

  crc_step_comb #(
    .CRC_WIDTH  (CRC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .crc_i  (step_crc_c),
    .data_i (step_data_c),
    .poly_i (step_poly_c),
    .crc_o  (crc_d)
  );

  // Output transform applied once at end of frame.
  always_comb begin
    result_c = (refout_q ? CRC_WIDTH'(bit_reverse(DATA_MAX_W'(crc_q), CRC_WIDTH))
                         : crc_q) ^ xorout_q;
  end

  // Frame FSM, config latch and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      crc_q     <= '0;
      poly_q    <= '0;
      xorout_q  <= '0;
      check_q   <= '0;
      refin_q   <= 1'b0;
      refout_q  <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_crc_q   <= '0;
      m_match_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (beat_acc_c) begin
            poly_q    <= cfg_poly;
            xorout_q  <= cfg_xorout;
            check_q   <= cfg_check;
            refin_q   <= cfg_refin;
            refout_q  <= cfg_refout;
            crc_q     <= crc_d;
            state_q   <= s_last ? FINAL : RUN;
            s_ready_q <= ~s_last;
          end else begin
            s_ready_q <= 1'b1;
          end
        end
        RUN: begin
          // abort wins over a concurrent beat, which is swallowed.
          if (abort) begin
            crc_q     <= '0;
            state_q   <= IDLE;
            s_ready_q <= 1'b1;
          end else if (beat_acc_c) begin
            crc_q <= crc_d;
            if (s_last) begin
              state_q   <= FINAL;
              s_ready_q <= 1'b0;
            end
          end
        end
        FINAL: begin
          m_crc_q   <= result_c;
          m_match_q <= (result_c == check_q);
          m_valid_q <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
            s_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_crc   = m_crc_q;
  assign m_match = m_match_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: three instances (8/16/32-bit CRC, 8-bit beats) share
// the beat and result handshakes; each has its own configuration.
module tb_crc_stream_engine;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_last;
  logic        abort;
  logic        m_ready;
  logic [7:0]  s_data;
  logic [31:0] c_poly [3];
  logic [31:0] c_init [3];
  logic [31:0] c_xor  [3];
  logic [31:0] c_chk  [3];
  logic        c_rin  [3];
  logic        c_rout [3];

  logic        s_ready8, s_ready16, s_ready32;
  logic        m_valid8, m_valid16, m_valid32;
  logic        match8, match16, match32;
  logic [7:0]  crc8;
  logic [15:0] crc16;
  logic [31:0] crc32;

  int n_pass  = 0;
  int n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  crc_stream_engine #(.CRC_WIDTH(8), .DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .cfg_poly(c_poly[0][7:0]), .cfg_init(c_init[0][7:0]), .cfg_xorout(c_xor[0][7:0]),
    .cfg_refin(c_rin[0]), .cfg_refout(c_rout[0]), .cfg_check(c_chk[0][7:0]),
    .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data), .s_last(s_last),
    .abort(abort), .m_valid(m_valid8), .m_ready(m_ready), .m_crc(crc8), .m_match(match8));

  crc_stream_engine #(.CRC_WIDTH(16), .DATA_WIDTH(8)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .cfg_poly(c_poly[1][15:0]), .cfg_init(c_init[1][15:0]), .cfg_xorout(c_xor[1][15:0]),
    .cfg_refin(c_rin[1]), .cfg_refout(c_rout[1]), .cfg_check(c_chk[1][15:0]),
    .s_valid(s_valid), .s_ready(s_ready16), .s_data(s_data), .s_last(s_last),
    .abort(abort), .m_valid(m_valid16), .m_ready(m_ready), .m_crc(crc16), .m_match(match16));

  crc_stream_engine #(.CRC_WIDTH(32), .DATA_WIDTH(8)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .cfg_poly(c_poly[2]), .cfg_init(c_init[2]), .cfg_xorout(c_xor[2]),
    .cfg_refin(c_rin[2]), .cfg_refout(c_rout[2]), .cfg_check(c_chk[2]),
    .s_valid(s_valid), .s_ready(s_ready32), .s_data(s_data), .s_last(s_last),
    .abort(abort), .m_valid(m_valid32), .m_ready(m_ready), .m_crc(crc32), .m_match(match32));

  function automatic int cw_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 16 : 32);
  endfunction

  function automatic logic [31:0] mask_of(input int k);
    return (k == 2) ? 32'hFFFF_FFFF : ((32'd1 << cw_of(k)) - 32'd1);
  endfunction

  function logic [31:0] crc_of(input int k);
    return (k == 0) ? 32'(crc8) : ((k == 1) ? 32'(crc16) : crc32);
  endfunction

  function logic match_of(input int k);
    return (k == 0) ? match8 : ((k == 1) ? match16 : match32);
  endfunction

  function logic valid_of(input int k);
    return (k == 0) ? m_valid8 : ((k == 1) ? m_valid16 : m_valid32);
  endfunction

  function logic ready_of(input int k);
    return (k == 0) ? s_ready8 : ((k == 1) ? s_ready16 : s_ready32);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, want);
  endtask

  // Reference: classic augmented long division. Init is folded into the first cw
  // message bits and cw zero bits are appended; valid for messages of >= cw bits.
  function automatic logic [31:0] ref_crc(input int cw, input logic [31:0] poly,
      input logic [31:0] init, input logic [31:0] xorout, input logic rin,
      input logic rout, input byte msg[$]);
    bit          bits[$];
    logic [31:0] mask;
    logic [31:0] rem;
    logic [31:0] r;
    bit          top;
    mask = (cw == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    foreach (msg[i]) begin
      for (int b = 0; b < 8; b++) bits.push_back(rin ? msg[i][b] : msg[i][7-b]);
    end
    for (int j = 0; j < cw; j++) bits[j] = bits[j] ^ init[cw-1-j];
    for (int j = 0; j < cw; j++) bits.push_back(1'b0);
    rem = '0;
    foreach (bits[j]) begin
      top = rem[cw-1];
      rem = ((rem << 1) | 32'(bits[j])) & mask;
      if (top) rem = rem ^ (poly & mask);
    end
    if (rout) begin
      r = '0;
      for (int i = 0; i < cw; i++) r[i] = rem[cw-1-i];
      rem = r;
    end
    return (rem ^ xorout) & mask;
  endfunction

  task automatic set_cfg(input int k, input logic [31:0] poly, input logic [31:0] init,
      input logic [31:0] xo, input logic rin, input logic rout, input logic [31:0] chkv);
    c_poly[k] = poly; c_init[k] = init; c_xor[k] = xo;
    c_rin[k]  = rin;  c_rout[k] = rout; c_chk[k] = chkv;
  endtask

  task automatic scramble_cfg();
    for (int k = 0; k < 3; k++) begin
      set_cfg(k, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom);
    end
  endtask

  // Present n beats; each beat waits (bounded) for s_ready and is accepted at the
  // following rising edge. Returns at the falling edge after the last acceptance.
  task automatic drive_beats(input byte msg[$], input int n, input bit last_on_end,
      input bit gaps, input bit toggle);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          s_valid = 1'b0;
          @(negedge clk);
        end
      end
      s_valid = 1'b1;
      s_data  = msg[i];
      s_last  = last_on_end && (i == n - 1);
      guard   = 0;
      while (!s_ready8 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (!s_ready8) begin
        chk("accept_timeout", 32'(s_ready8), 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(negedge clk);
      if (toggle) scramble_cfg();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Full frame with latency, result and handshake checks; hold>0 stalls m_ready.
  task automatic run_frame(input byte msg[$], input bit gaps, input bit toggle, input int hold);
    logic [31:0] want [3];
    logic        wmat [3];
    bit          use_k[3];
    for (int k = 0; k < 3; k++) begin
      use_k[k] = (msg.size() * 8 >= cw_of(k));
      want[k]  = use_k[k] ? ref_crc(cw_of(k), c_poly[k], c_init[k], c_xor[k], c_rin[k],
                                    c_rout[k], msg) : 32'd0;
      wmat[k]  = (want[k] == (c_chk[k] & mask_of(k)));
    end
    m_ready = (hold == 0);
    drive_beats(msg, msg.size(), 1'b1, gaps, toggle);
    chk("latency_not_yet", 32'(m_valid8), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("latency_valid_w%0d", cw_of(k)), 32'(valid_of(k)), 32'd1);
      if (use_k[k]) begin
        chk($sformatf("crc_model_w%0d", cw_of(k)), crc_of(k), want[k]);
        chk($sformatf("match_model_w%0d", cw_of(k)), 32'(match_of(k)), 32'(wmat[k]));
      end
    end
    if (hold > 0) begin
      s_valid = 1'b1;
      s_data  = msg[0];
      s_last  = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        chk("bp_valid_held", 32'(m_valid8), 32'd1);
        chk("bp_sready_low", 32'(s_ready8), 32'd0);
        chk("bp_crc_stable", crc_of(0), want[0]);
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("handshake_clear_w%0d", cw_of(k)), 32'(valid_of(k)), 32'd0);
      chk($sformatf("ready_after_w%0d", cw_of(k)), 32'(ready_of(k)), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_sready_w%0d", tag, cw_of(k)), 32'(ready_of(k)), 32'd0);
      chk($sformatf("%s_mvalid_w%0d", tag, cw_of(k)), 32'(valid_of(k)), 32'd0);
      chk($sformatf("%s_mcrc_w%0d", tag, cw_of(k)), crc_of(k), 32'd0);
      chk($sformatf("%s_mmatch_w%0d", tag, cw_of(k)), 32'(match_of(k)), 32'd0);
    end
  endtask

  initial begin
    byte msg9[$];
    byte one[$];
    byte rnd[$];
    for (int i = 0; i < 9; i++) msg9.push_back(8'(8'h31 + i));
    one.push_back(8'h31);

    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    abort = 1'b0; m_ready = 1'b1;
    set_cfg(0, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0, 32'hF4);
    set_cfg(1, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0, 32'h29B1);
    set_cfg(2, 32'h04C11DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hCBF4_3926);

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(s_ready8), 32'd1);

    // Catalogue check values.
    run_frame(msg9, 1'b0, 1'b0, 0);
    chk("smbus_crc", crc_of(0), 32'hF4);
    chk("smbus_match", 32'(match8), 32'd1);
    chk("ccitt_false_crc", crc_of(1), 32'h29B1);
    chk("crc32_eth_crc", crc_of(2), 32'hCBF4_3926);
    chk("crc32_eth_match", 32'(match32), 32'd1);

    set_cfg(0, 32'hD5, 32'h00, 32'h00, 1'b0, 1'b0, 32'hBC);
    run_frame(msg9, 1'b0, 1'b0, 0);
    chk("dvb_s2_crc", crc_of(0), 32'hBC);

    set_cfg(0, 32'h1D, 32'h00, 32'h00, 1'b0, 1'b0, 32'h00);
    run_frame(msg9, 1'b0, 1'b0, 0);
    chk("gsm_a_crc", crc_of(0), 32'h37);
    chk("gsm_a_nomatch", 32'(match8), 32'd0);

    // Result backpressure, then the stalled frame is sent again.
    set_cfg(0, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0, 32'hF4);
    run_frame(msg9, 1'b0, 1'b0, 10);
    chk("bp_first_crc", crc_of(0), 32'hF4);
    run_frame(msg9, 1'b0, 1'b0, 0);
    chk("bp_second_crc", crc_of(0), 32'hF4);

    // Gaps on s_valid plus cfg scrambled after each beat.
    run_frame(msg9, 1'b1, 1'b1, 0);
    chk("gaps_toggle_crc", crc_of(0), 32'hF4);

    // Single-beat frame.
    set_cfg(0, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0, 32'h97);
    set_cfg(1, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0, 32'h29B1);
    set_cfg(2, 32'h04C11DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hCBF4_3926);
    run_frame(one, 1'b0, 1'b0, 0);
    chk("single_beat_crc", crc_of(0), 32'h97);
    chk("single_beat_match", 32'(match8), 32'd1);

    // Abort after four beats, with a beat presented on the abort cycle.
    set_cfg(0, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0, 32'hF4);
    drive_beats(msg9, 4, 1'b0, 1'b0, 1'b0);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h35;
    @(negedge clk);
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("abort_ready", 32'(s_ready8), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_result", 32'(m_valid8), 32'd0);
    end
    run_frame(msg9, 1'b0, 1'b0, 0);
    chk("after_abort_crc", crc_of(0), 32'hF4);

    // Reset mid-frame.
    drive_beats(msg9, 3, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("midreset");
    @(negedge clk);
    chk("midreset_ready_back", 32'(s_ready8), 32'd1);
    run_frame(msg9, 1'b0, 1'b0, 0);
    chk("after_reset_crc", crc_of(0), 32'hF4);

    // Random frames and configurations against the division model.
    for (int it = 0; it < 6; it++) begin
      rnd.delete();
      repeat ($urandom_range(4, 12)) rnd.push_back(8'($urandom));
      scramble_cfg();
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 1) == 1)
          c_chk[k] = ref_crc(cw_of(k), c_poly[k], c_init[k], c_xor[k], c_rin[k], c_rout[k], rnd);
      end
      run_frame(rnd, 1'b1, 1'(it % 2), (it == 3) ? 3 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
